// File: rtl/mole_pkg.sv
// Shared constants and helpers for the mole spawner and the hit-matching logic.
package mole_pkg;

    localparam int NUM_MOLES  = 5;
    localparam int LFSR_WIDTH = 8;
    // x^8 + x^6 + x^5 + x^4 + 1, taken from q[7], q[5], q[4], q[3]
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [2:0] HIT_NONE = 3'b000;
    localparam logic [2:0] HIT_MAX  = 3'b101;

    // Code 1..5 selects hole 0..4; anything else yields an empty mask.
    function automatic logic [NUM_MOLES-1:0] hit_to_index(input logic [2:0] code);
        logic [NUM_MOLES-1:0] mask;
        mask = '0;
        if (code != HIT_NONE && code <= HIT_MAX) begin
            mask[code - 3'd1] = 1'b1;
        end
        return mask;
    endfunction

    function automatic logic [2:0] count_ones(input logic [NUM_MOLES-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Seedable 8-bit Fibonacci LFSR; shifts left and advances only while enabled.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic [LFSR_WIDTH-1:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= SEED;
        end else if (enable) begin
            q <= {q[LFSR_WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Spawns moles into free holes on a fixed cadence and retires them on hit or timeout.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int                    SPAWN_INTERVAL = 50_000_000,
    parameter int                    MOLE_LIFETIME  = 100_000_000,
    parameter int                    MAX_ACTIVE     = 3,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           moleHit,
    output logic [NUM_MOLES-1:0] molesGenerated,
    output logic [2:0]           activeCount,
    output logic                 moleExpired
);

    localparam int TW = $clog2(SPAWN_INTERVAL);
    localparam int CW = $clog2(MOLE_LIFETIME);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [TW-1:0]         spawn_timer;
    logic [CW-1:0]         life [NUM_MOLES];

    logic [NUM_MOLES-1:0] hit_mask, expire_mask, clear_mask, free_mask, spawn_mask, next_moles;
    logic                 attempt, expired_unhit;
    logic [2:0]           start, idx;
    logic [3:0]           sum;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .q      (lfsr_q)
    );

    always_comb begin
        hit_mask = hit_to_index(moleHit) & molesGenerated;
        for (int i = 0; i < NUM_MOLES; i++) begin
            expire_mask[i] = molesGenerated[i] && (life[i] == '0);
        end
        clear_mask    = hit_mask | expire_mask;
        // A hit on the expiring hole claims it, so no timeout pulse.
        expired_unhit = |(expire_mask & ~hit_mask);
        free_mask     = ~molesGenerated & ~clear_mask;
        attempt       = (spawn_timer == TW'(SPAWN_INTERVAL - 1));
        start         = (lfsr_q[2:0] >= 3'd5) ? (lfsr_q[2:0] - 3'd5) : lfsr_q[2:0];

        spawn_mask = '0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            sum = 4'(start) + 4'(i);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : 3'(sum);
            if (spawn_mask == '0 && free_mask[idx]) begin
                spawn_mask[idx] = 1'b1;
            end
        end
        if (!attempt || int'(activeCount) >= MAX_ACTIVE) begin
            spawn_mask = '0;
        end

        next_moles = (molesGenerated & ~clear_mask) | spawn_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spawn_timer    <= '0;
            molesGenerated <= '0;
            activeCount    <= '0;
            moleExpired    <= 1'b0;
            for (int i = 0; i < NUM_MOLES; i++) begin
                life[i] <= '0;
            end
        end else if (enable) begin
            spawn_timer    <= attempt ? '0 : spawn_timer + TW'(1);
            molesGenerated <= next_moles;
            activeCount    <= count_ones(next_moles);
            moleExpired    <= expired_unhit;
            for (int i = 0; i < NUM_MOLES; i++) begin
                if (spawn_mask[i]) begin
                    life[i] <= CW'(MOLE_LIFETIME - 1);
                end else if (molesGenerated[i] && life[i] != '0) begin
                    life[i] <= life[i] - CW'(1);
                end
            end
        end else begin
            moleExpired <= 1'b0;
        end
    end

endmodule
